wam_judge: RTL and testbench
============================

WAM_JUDGE -- requirements
Module: wam_judge

Interface
REQ-001 Parameter DEB_CYC, default 4: consecutive clk samples a button must be stable high/low before its debounced level changes; legal range 2..255.
REQ-002 Parameter GAME_TICKS, default 60: game length in tick pulses; legal range 1..255.
REQ-003 Parameter MAX_MISS, default 9: escape count that ends the game; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clr  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a game.
REQ-007 tick  in  1  one-cycle game-time pulse (e.g. 1 Hz strobe).
REQ-008 holes  in  8  mole-present flags from the mole generator; bit i = hole i.
REQ-009 btn  in  8  raw player buttons, synchronised, active-high; bit i = hole i.
REQ-010 whack  out  8  one-cycle kill pulse per hole back to the mole generator.
REQ-011 hit  out  1  one-cycle pulse when at least one hit registers.
REQ-012 score  out  8  hit total, saturating.
REQ-013 miss  out  4  escaped-mole total, saturating.
REQ-014 time_left  out  8  remaining ticks.
REQ-015 done  out  1  high while in OVER.

Function
REQ-016 FSM states IDLE, PLAY, OVER; IDLE->PLAY and OVER->PLAY on start; PLAY->OVER when time_left reaches 0 or miss reaches MAX_MISS; start in PLAY is ignored.
REQ-017 Entering PLAY loads score=0, miss=0, time_left=GAME_TICKS; clears all debounce counters, debounced levels and claimed bits.
REQ-018 Debounce per button: counter increments while btn[i] differs from debounced level, resets to 0 when equal; when counter reaches DEB_CYC, debounced level toggles and counter resets.
REQ-019 Press event i = one-cycle pulse on 0->1 transition of debounced level i; btn held high from before edge 1 sets debounced level at edge DEB_CYC, and its press effect (score/whack/hit) appears after edge DEB_CYC+1.
REQ-020 In PLAY, press event i with holes[i]=1 and claimed[i]=0 -> hit: whack[i]=1 for one cycle, claimed[i] set, score += 1.
REQ-021 Simultaneous press events on several holes: every qualifying hole is a hit in the same cycle; score += popcount(hits), saturating at 255; hit asserted once.
REQ-022 Press event on a hole with holes[i]=0 or claimed[i]=1 -> no hit, no whack (penalty per REQ-033).
REQ-023 Escape: holes[i] sampled 1 at previous edge and 0 now with claimed[i]=0 -> miss += 1 per escaping hole, saturating at 15; fall with claimed[i]=1 clears claimed[i], no miss.
REQ-024 Hit and fall on the same hole in the same cycle counts as hit, not escape.
REQ-025 tick in PLAY decrements time_left (never below 0); time_left reaching 0 and miss reaching MAX_MISS in the same cycle -> OVER once.
REQ-026 Transition to OVER occurs at the edge after the terminating condition registers; hits/escapes registered in that same cycle still count.
REQ-027 In IDLE/OVER: whack=0, hit=0, score/miss/time_left hold, ticks and presses ignored; debounce continues.
REQ-028 done=1 exactly in OVER; hit and whack never high outside PLAY.

Reset
REQ-029 clr=1 at a rising edge forces IDLE, score=0, miss=0, time_left=0, whack=0, hit=0, done=0, all debounce/claimed/previous-holes state 0.
REQ-030 clr has priority over start, tick and press events in the same cycle.
REQ-031 clr asserted mid-game aborts the game; no partial score retained.

Configuration
REQ-032 Macro WAM_PENALTY_EN selects the empty-press penalty.
REQ-033 With WAM_PENALTY_EN defined: each non-hit press event in PLAY decrements score by 1, saturating at 0; net change = hits - penalties in one cycle, clamped to 0..255. Without it: non-hit presses have no effect.

Verification
REQ-034 DEB_CYC=4; start; holes=8'h04; btn[2] high from before edge 1 -> whack=8'h04 and hit=1 for one cycle after edge 5, score=1.
REQ-035 btn[5] high 3 cycles then low, holes[5]=1 -> no whack, score stays 0 (glitch rejected).
REQ-036 holes=8'h81, btn[0] and btn[7] debounce together -> whack=8'h81, single hit pulse, score +2.
REQ-037 MAX_MISS=9; nine moles fall unwhacked -> miss=9, done=1 next cycle, further presses ignored.
REQ-038 GAME_TICKS=3; three tick pulses -> time_left 3->0, OVER; start -> PLAY, score=0, time_left=3.
REQ-039 WAM_PENALTY_EN defined, score=0, empty press -> score stays 0; score=5, empty press -> 4; without macro -> 5.

Source files
------------

// File: rtl/wam_judge_if.sv
// Whack-a-mole judge bus: game controls, mole flags, player buttons and judge results.
// The judge attaches through the slave modport and the driving environment through master.
interface wam_judge_if;
    logic       start;
    logic       tick;
    logic [7:0] holes;
    logic [7:0] btn;
    logic [7:0] whack;
    logic       hit;
    logic [7:0] score;
    logic [3:0] miss;
    logic [7:0] time_left;
    logic       done;

    modport master (
        output start, tick, holes, btn,
        input  whack, hit, score, miss, time_left, done
    );

    modport slave (
        input  start, tick, holes, btn,
        output whack, hit, score, miss, time_left, done
    );
endinterface

// File: rtl/wam_judge.sv
// Whack-a-mole judge: per-button debounce, hit/escape scoring and game timer FSM.
// Optional macro WAM_PENALTY_EN: non-hit presses during play cost one point each.
module wam_judge #(
    parameter int unsigned DEB_CYC    = 4,
    parameter int unsigned GAME_TICKS = 60,
    parameter int unsigned MAX_MISS   = 9
) (
    input  logic        clk,
    input  logic        clr,
    wam_judge_if.slave  bus
);
    localparam int unsigned NH = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 9;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt   [NH];
    logic [CW-1:0]   cnt_n [NH];
    logic [NH-1:0]   deb, deb_n, deb_d;
    logic [NH-1:0]   holes_q, claimed, claimed_n;
    logic [7:0]      score_q, score_n;
    logic [3:0]      miss_q, miss_n;
    logic [7:0]      tl_q, tl_n;
    logic [NH-1:0]   whack_q;
    logic            hit_q, done_q;

    logic            play_c, enter_play_c;
    logic [NH-1:0]   press_c, hit_vec_c, fall_c, esc_c;
    logic [SW-1:0]   sum_up_c, sum_adj_c;
    logic [4:0]      miss_sum_c;
`ifdef WAM_PENALTY_EN
    logic [NH-1:0]   empty_c;
    logic [SW-1:0]   pen_c;
`endif

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Game FSM next state; termination is judged on already-registered counters
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start) state_n = PLAY;
            PLAY: if (tl_q == 8'd0 || miss_q >= 4'(MAX_MISS)) state_n = OVER;
            OVER: if (bus.start) state_n = PLAY;
            default: state_n = IDLE;
        endcase
    end

    // Debounce: level flips once the raw input has disagreed for DEB_CYC samples
    always_comb begin
        deb_n = deb;
        for (int i = 0; i < NH; i++) begin
            cnt_n[i] = '0;
            if (bus.btn[i] != deb[i]) begin
                if (cnt[i] == CW'(DEB_CYC - 1)) begin
                    deb_n[i] = ~deb[i];
                end else begin
                    cnt_n[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Hit, escape and scoring arithmetic for the current cycle
    always_comb begin
        play_c       = (state == PLAY);
        enter_play_c = (state != PLAY) && (state_n == PLAY);
        press_c      = deb & ~deb_d;
        fall_c       = holes_q & ~bus.holes;
        hit_vec_c    = '0;
        esc_c        = '0;
        claimed_n    = claimed;
        tl_n         = tl_q;
        if (play_c) begin
            hit_vec_c = press_c & bus.holes & ~claimed;
            esc_c     = fall_c & ~claimed & ~hit_vec_c;
            claimed_n = (claimed & ~fall_c) | hit_vec_c;
            if (bus.tick && tl_q != 8'd0) tl_n = tl_q - 8'd1;
        end

        sum_up_c = SW'(score_q) + SW'(pop8(hit_vec_c));
`ifdef WAM_PENALTY_EN
        empty_c = play_c ? (press_c & ~hit_vec_c) : '0;
        pen_c   = SW'(pop8(empty_c));
        sum_adj_c = (sum_up_c < pen_c) ? '0 : (sum_up_c - pen_c);
`else
        sum_adj_c = sum_up_c;
`endif
        score_n = (sum_adj_c > SW'(255)) ? 8'hFF : sum_adj_c[7:0];

        miss_sum_c = 5'(miss_q) + 5'(pop8(esc_c));
        miss_n     = (miss_sum_c > 5'd15) ? 4'hF : miss_sum_c[3:0];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            deb     <= '0;
            deb_d   <= '0;
            holes_q <= '0;
            claimed <= '0;
            score_q <= '0;
            miss_q  <= '0;
            tl_q    <= '0;
            whack_q <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NH; i++) cnt[i] <= '0;
        end else begin
            state   <= state_n;
            holes_q <= bus.holes;
            done_q  <= (state_n == OVER);
            if (enter_play_c) begin
                deb     <= '0;
                deb_d   <= '0;
                claimed <= '0;
                score_q <= '0;
                miss_q  <= '0;
                tl_q    <= 8'(GAME_TICKS);
                whack_q <= '0;
                hit_q   <= 1'b0;
                for (int i = 0; i < NH; i++) cnt[i] <= '0;
            end else begin
                deb     <= deb_n;
                deb_d   <= deb;
                claimed <= claimed_n;
                tl_q    <= tl_n;
                for (int i = 0; i < NH; i++) cnt[i] <= cnt_n[i];
                if (play_c) begin
                    score_q <= score_n;
                    miss_q  <= miss_n;
                end
                // Kill pulses only go out while the game is still running
                whack_q <= (state_n == PLAY) ? hit_vec_c : '0;
                hit_q   <= (state_n == PLAY) && (|hit_vec_c);
            end
        end
    end

    assign bus.whack     = whack_q;
    assign bus.hit       = hit_q;
    assign bus.score     = score_q;
    assign bus.miss      = miss_q;
    assign bus.time_left = tl_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_wam_judge.sv
// Randomised bench for wam_judge: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_wam_judge;
    localparam int unsigned DEB = 4;
    localparam int unsigned GT  = 20;
    localparam int unsigned MM  = 9;
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    wam_judge_if bus();

    wam_judge #(.DEB_CYC(DEB), .GAME_TICKS(GT), .MAX_MISS(MM)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] whack;
        logic       hit;
        logic [7:0] score;
        logic [3:0] miss;
        logic [7:0] tl;
        logic       done;
    } obs_t;

    obs_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model state, kept as plain integers and bit vectors
    int       m_mode = M_IDLE;
    int       m_score = 0, m_miss = 0, m_tl = 0;
    bit [7:0] m_lvl = '0, m_lvl_prev = '0, m_claim = '0, m_hprev = '0;
    int       m_run[8];

    task automatic model_reset();
        m_mode = M_IDLE; m_score = 0; m_miss = 0; m_tl = 0;
        m_lvl = '0; m_lvl_prev = '0; m_claim = '0; m_hprev = '0;
        foreach (m_run[i]) m_run[i] = 0;
    endtask

    always @(posedge clk) begin
        bit [7:0] press, hits, empt, esc, fall;
        int       nm, s;
        obs_t     e;
        cyc++;
        if (clr) begin
            model_reset();
            e = '0;
        end else begin
            press = m_lvl & ~m_lvl_prev;
            fall  = m_hprev & ~bus.holes;
            hits = '0; empt = '0; esc = '0;
            nm = m_mode;
            if (m_mode != M_PLAY && bus.start) nm = M_PLAY;
            else if (m_mode == M_PLAY && (m_tl == 0 || m_miss >= int'(MM))) nm = M_OVER;

            if (m_mode == M_PLAY) begin
                hits = press & bus.holes & ~m_claim;
                empt = press & ~hits;
                esc  = fall & ~m_claim & ~hits;
                s = m_score + $countones(hits);
`ifdef WAM_PENALTY_EN
                s = s - $countones(empt);
`endif
                m_score = (s < 0) ? 0 : (s > 255) ? 255 : s;
                m_miss  = (m_miss + $countones(esc) > 15) ? 15 : m_miss + $countones(esc);
                if (bus.tick && m_tl > 0) m_tl = m_tl - 1;
                m_claim = (m_claim & ~fall) | hits;
            end

            if (m_mode != M_PLAY && nm == M_PLAY) begin
                m_score = 0; m_miss = 0; m_tl = GT;
                m_claim = '0; m_lvl = '0; m_lvl_prev = '0;
                foreach (m_run[i]) m_run[i] = 0;
            end else begin
                m_lvl_prev = m_lvl;
                for (int i = 0; i < 8; i++) begin
                    if (bus.btn[i] != m_lvl[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == int'(DEB)) begin
                            m_lvl[i] = ~m_lvl[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_hprev = bus.holes;
            m_mode  = nm;
            e.whack = (nm == M_PLAY) ? hits : 8'h00;
            e.hit   = (nm == M_PLAY) && (hits != 8'h00);
            e.score = 8'(m_score);
            e.miss  = 4'(m_miss);
            e.tl    = 8'(m_tl);
            e.done  = (nm == M_OVER);
        end
        expq.push_back(e);
    end

    // Monitor: every cycle the DUT presents a full output set
    always @(negedge clk) begin
        obs_t e, g;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = '{bus.whack, bus.hit, bus.score, bus.miss, bus.time_left, bus.done};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got whack=%h hit=%b score=%0d miss=%0d tl=%0d done=%b want whack=%h hit=%b score=%0d miss=%0d tl=%0d done=%b",
                         cyc, g.whack, g.hit, g.score, g.miss, g.tl, g.done,
                         e.whack, e.hit, e.score, e.miss, e.tl, e.done);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [7:0] h, input logic [7:0] b, input int n);
        bus.holes = h;
        bus.btn   = b;
        step(n);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.tick = 1'b0; bus.holes = '0; bus.btn = '0;
        step(3);
        clr = 1'b0;

        // Single debounced press on a live hole, then a 3-cycle glitch, then a two-hole press
        pulse_start();
        drive(8'h04, 8'h04, 8);
        drive(8'h04, 8'h00, 6);
        drive(8'h20, 8'h20, 3);
        drive(8'h20, 8'h00, 6);
        drive(8'h81, 8'h81, 7);
        drive(8'h81, 8'h00, 6);

        // Randomised play: slowly varying buttons and holes, sporadic ticks, starts and clears
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(5, 0) == 0) bus.btn[i] = ~bus.btn[i];
                if ($urandom_range(19, 0) == 0) bus.holes[i] = ~bus.holes[i];
            end
            bus.tick  = ($urandom_range(9, 0) == 0);
            bus.start = ($urandom_range(39, 0) == 0);
            clr       = ($urandom_range(399, 0) == 0);
            step(1);
        end
        bus.tick = 1'b0; bus.start = 1'b0; clr = 1'b0;

        // Score saturation: many full-board rounds with no ticks and no escapes
        clr = 1'b1; drive(8'h00, 8'h00, 1); clr = 1'b0;
        pulse_start();
        for (int r = 0; r < 36; r++) begin
            drive(8'hFF, 8'hFF, 6);
            drive(8'hFF, 8'h00, 6);
            drive(8'h00, 8'h00, 1);
        end
        // Empty presses at saturated score, then escape saturation beyond the game-ending count
        drive(8'h00, 8'h08, 6);
        drive(8'h00, 8'h00, 6);
        drive(8'hFF, 8'h00, 1);
        drive(8'h00, 8'h00, 1);
        drive(8'hFF, 8'h00, 1);
        drive(8'h00, 8'h00, 3);
        // Presses while over are ignored; restart; clear mid-game
        drive(8'h10, 8'h10, 8);
        drive(8'h10, 8'h00, 2);
        pulse_start();
        drive(8'h10, 8'h10, 7);
        bus.tick = 1'b1;
        step(4);
        bus.tick = 1'b0;
        clr = 1'b1; bus.start = 1'b1; step(1);
        clr = 1'b0; bus.start = 1'b0;
        step(4);

        @(negedge clk);
        #1;
        n_cmp++;
        if (expq.size() > 1) begin
            n_bad++;
            $display("FAIL queue_drain got %0d pending want <=1", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
